// File: rtl/stream_feeder_pkg.sv
// rtl/stream_feeder_pkg.sv - shared state type and default parameters for stream_feeder
package stream_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_WINDOW     = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous count-based sample buffer, head visible combinationally
module sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_feeder.sv
// rtl/stream_feeder.sv - buffers samples and feeds them in fixed windows to a tracker,
// pulsing window_clear after each window's final sample has been presented.
module stream_feeder
  import stream_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int WINDOW     = DEFAULT_WINDOW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  window_clear
);

  localparam int CW = $clog2(WINDOW);

  state_t                state, state_next;
  logic [CW-1:0]         sample_cnt;
  logic                  wr_en, rd_en, last_read;
  logic [DATA_WIDTH-1:0] head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_full, fifo_empty;

  // Ready comes from the registered count only, so a full buffer never takes a bypass write.
  assign din_ready = !reset && !fifo_full;
  assign wr_en     = din_valid && din_ready;
  assign last_read = rd_en && (sample_cnt == CW'(WINDOW - 1));

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (din),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (last_read) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    rd_en = (state == RUN) && !fifo_empty && !hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt   <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      window_clear <= 1'b0;
    end else begin
      if (last_read)  sample_cnt <= '0;
      else if (rd_en) sample_cnt <= sample_cnt + 1'b1;
      // Idle dout is forced to zero so the tracker never sees a stale value as new data.
      dout         <= rd_en ? head : '0;
      dout_valid   <= rd_en;
      window_clear <= (state == CLEAR);
    end
  end

endmodule

// File: doc/stream_feeder.md
STREAM_FEEDER -- requirements
Module: stream_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample width.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, >=2.
REQ-003 Parameter WINDOW, default 8, samples per window; >=2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  DATA_WIDTH  unsigned sample from producer.
REQ-007 din_valid  input  1  din holds a sample this cycle.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 hold  input  1  stall draining; buffer keeps filling.
REQ-010 dout  output  DATA_WIDTH  sample to downstream second-largest tracker; 0 when dout_valid low.
REQ-011 dout_valid  output  1  dout carries a real sample.
REQ-012 window_clear  output  1  one-cycle pulse; drives tracker reset (tracker resetn = ~window_clear).

Function
REQ-013 Accept: write occurs when din_valid && din_ready; din_ready SHALL equal (count != DEPTH), from registered count only.
REQ-014 Full buffer: din_ready low even if a read occurs same cycle; no write bypass.
REQ-015 FSM states RUN, CLEAR; reset state RUN.
REQ-016 Read occurs when state==RUN && count!=0 && !hold; head entry removed, FIFO order preserved.
REQ-017 Simultaneous read and write: count unchanged, both performed.
REQ-018 dout/dout_valid registered: cycle after a read, dout=head value, dout_valid=1; otherwise dout=0, dout_valid=0 (latency 1 from read, min 2 cycles din->dout).
REQ-019 Sample counter (width clog2(WINDOW)) increments per read; on read with counter==WINDOW-1, counter wraps to 0 and FSM goes RUN->CLEAR.
REQ-020 CLEAR lasts exactly one cycle, no read in CLEAR regardless of hold; CLEAR->RUN unconditionally.
REQ-021 window_clear registered from (state==CLEAR): asserted exactly 2 cycles after last window read, i.e. the cycle after the last sample's dout_valid; during that cycle tracker output equals the window result.
REQ-022 Reads may resume in the window_clear cycle; first new sample appears at dout the cycle after window_clear.
REQ-023 hold during RUN freezes counter and FSM; hold does not affect accepts.
REQ-024 Zero-valued idle dout is safe for the tracker (never exceeds stored values).

Reset
REQ-025 reset SHALL flush buffer (count=0, pointers=0), counter=0, state=RUN.
REQ-026 During and first cycle after reset: dout=0, dout_valid=0, window_clear=0, din_ready=0 while reset high, 1 after.
REQ-027 Reset mid-window or mid-CLEAR discards buffered samples and any pending window_clear.

Structure
REQ-028 Package stream_feeder_pkg SHALL hold state enum (RUN, CLEAR) and default parameter constants.
REQ-029 Buffer SHALL be one sub-module sample_fifo (synchronous, count-based full/empty); FSM, counter, output registers in stream_feeder.

Verification (DEPTH=4, WINDOW=4)
REQ-030 Reset, then samples 5,9,3,7 back-to-back, hold=0 -> dout_valid cycles carry 5,9,3,7 in order; window_clear one cycle after the 7; tracker reads 7 that cycle.
REQ-031 hold=1, push 1,2,3,4,5 -> 1..4 accepted, din_ready low after 4th, 5 held by producer; release hold -> 1,2,3,4 out, then 5 accepted.
REQ-032 Full buffer with read and din_valid same cycle -> no write that cycle; count drops to 3.
REQ-033 Continuous stream 1..8 -> window_clear after 4th and 8th output; no dout_valid in the cycle following each CLEAR read gap; no sample lost.
REQ-034 Reset asserted after 2 of 4 window samples read with 2 buffered -> all outputs 0, count 0; next 4 samples form a full window.
REQ-035 hold asserted on the 4th-sample cycle -> no read, no CLEAR until hold released.
